// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU and its arbiter.
//                - alu_op_t : 2-bit ALU operation code
//                - FLAG_*   : bit positions inside the 4-bit {N,Z,C,V} flag word
//                - ALU_WIDTH: default datapath width
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational ADD/SUB/AND/OR unit with {N,Z,C,V} flags.
//                C is the adder carry-out; for SUB it is the "no borrow"
//                indication (a >= b unsigned). C and V are zero for logic ops.
//  Ports       : a, b     [WIDTH]  operands
//                control  [2]      operation (alu_op_t encoding)
//                result   [WIDTH]  operation result
//                flags    [4]      {N,Z,C,V}
//  Revision    : 1.0  initial release
// ============================================================================
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       control,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             carry;
   logic             ovf;

   // Subtraction shares the adder: a + ~b + 1.
   assign is_sub = (control == ALU_SUB);
   assign b_eff  = is_sub ? ~b : b;
   assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (alu_op_t'(control))
         ALU_ADD, ALU_SUB: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
            // Overflow: both adder inputs share a sign that the sum lacks.
            ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         default: result = '0;
      endcase
   end

   always_comb begin
      flags         = '0;
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
   end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The search for the next grant starts at
//                last_grant+1 and wraps modulo N. The pointer moves only when
//                the owner signals an accepted transfer via advance.
//  Ports       : clk, rst           clock, asynchronous active-high reset
//                eligible   [N]     ports allowed to win this cycle
//                advance            transfer accepted this cycle
//                grant      [N]     one-hot (or zero) winner
//                last_grant [clog2] index of the most recent winner
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         eligible,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] last_grant
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] next_ptr;
   logic [PW-1:0] idx;
   logic          found;
   int            cand;

   // Walk N candidates starting one past the previous winner; the last
   // candidate visited is the previous winner itself.
   always_comb begin
      grant    = '0;
      next_ptr = last_grant;
      found    = 1'b0;
      idx      = '0;
      cand     = 0;
      for (int off = 1; off <= N; off++) begin
         cand = int'(last_grant) + off;
         if (cand >= N) begin
            cand = cand - N;
         end
         idx = PW'(cand);
         if (!found && eligible[idx]) begin
            grant[idx] = 1'b1;
            next_ptr   = idx;
            found      = 1'b1;
         end
      end
   end

   // Reset to N-1 so that port 0 wins the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= PW'(N - 1);
      end else if (advance && found) begin
         last_grant <= next_ptr;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one alu between N_REQ requesters. One operation is
//                accepted per cycle in round-robin order; the result and
//                flags are registered in a per-port response slot so a
//                stalled consumer only blocks its own port.
//  Ports       : clk, rst                  clock, async active-high reset
//                req_valid   [N_REQ]       request present
//                req_ready   [N_REQ]       request accepted (one-hot/zero)
//                req_a/b     [N_REQ][W]    operands
//                req_control [N_REQ][2]    alu_op_t op code
//                rsp_valid   [N_REQ]       response held
//                rsp_ready   [N_REQ]       consumer takes response
//                rsp_result  [N_REQ][W]    registered result
//                rsp_flags   [N_REQ][4]    registered {N,Z,C,V}
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int N_REQ = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
   input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
   input  logic [N_REQ-1:0][1:0]       req_control,
   output logic [N_REQ-1:0]            rsp_valid,
   input  logic [N_REQ-1:0]            rsp_ready,
   output logic [N_REQ-1:0][WIDTH-1:0] rsp_result,
   output logic [N_REQ-1:0][3:0]       rsp_flags
);

   logic [N_REQ-1:0]         eligible;
   logic [N_REQ-1:0]         grant;
   logic [$clog2(N_REQ)-1:0] last_grant;
   logic                     accept;

   logic [WIDTH-1:0]         sel_a;
   logic [WIDTH-1:0]         sel_b;
   logic [1:0]               sel_control;
   logic [WIDTH-1:0]         alu_result;
   logic [3:0]               alu_flags;

   // A port may win if its slot is empty or is being drained this cycle.
   assign eligible = req_valid & (~rsp_valid | rsp_ready);

   // Suppress grants while reset is held so nothing is accepted into a
   // slot that is being cleared.
   assign req_ready = grant & {N_REQ{~rst}};
   assign accept    = |req_ready;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr_arbiter (
      .clk        (clk),
      .rst        (rst),
      .eligible   (eligible),
      .advance    (accept),
      .grant      (grant),
      .last_grant (last_grant)
   );

   // Operand mux driven by the one-hot grant.
   always_comb begin
      sel_a       = '0;
      sel_b       = '0;
      sel_control = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_a       = req_a[i];
            sel_b       = req_b[i];
            sel_control = req_control[i];
         end
      end
   end

   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a       (sel_a),
      .b       (sel_b),
      .control (sel_control),
      .result  (alu_result),
      .flags   (alu_flags)
   );

   // Response slots: a refill takes priority over a drain, so a port that
   // is drained and re-granted in the same cycle keeps rsp_valid high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
               rsp_valid[i]  <= 1'b1;
               rsp_result[i] <= alu_result;
               rsp_flags[i]  <= alu_flags;
            end else if (rsp_ready[i]) begin
               rsp_valid[i]  <= 1'b0;
            end
         end
      end
   end

   ap_grant_onehot : assert property (@(posedge clk) disable iff (rst)
      $onehot0(req_ready));

   // Guards the wrap arithmetic when N_REQ is not a power of two.
   ap_ptr_range : assert property (@(posedge clk) disable iff (rst)
      int'(last_grant) < N_REQ);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter (N_REQ=2, WIDTH=32).
//                Directed vector table, multi-cycle corner sequences and a
//                randomized run against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int WIDTH = 32;
   localparam int N_REQ = 2;
   localparam int N_RAND = 10000;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ-1:0][WIDTH-1:0] req_a;
   logic [N_REQ-1:0][WIDTH-1:0] req_b;
   logic [N_REQ-1:0][1:0]       req_control;
   logic [N_REQ-1:0]            rsp_valid;
   logic [N_REQ-1:0]            rsp_ready;
   logic [N_REQ-1:0][WIDTH-1:0] rsp_result;
   logic [N_REQ-1:0][3:0]       rsp_flags;

   always #5 clk = ~clk;

   alu_arbiter #(
      .WIDTH (WIDTH),
      .N_REQ (N_REQ)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_control (req_control),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_flags   (rsp_flags)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference ALU from arithmetic definitions: returns {N,Z,C,V, result}.
   function automatic logic [35:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      logic        c;
      logic        v;
      longint      sa;
      longint      sb;
      longint      sr;
      longint      ua;
      longint      ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      c  = 1'b0;
      v  = 1'b0;
      sr = 0;
      case (op)
         2'd0: begin
            r  = a + b;
            c  = (ua + ub) > 64'sd4294967295;
            sr = sa + sb;
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         2'd1: begin
            r  = a - b;
            c  = (ua >= ub);
            sr = sa - sb;
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         2'd2:    r = a & b;
         default: r = a | b;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   typedef struct {
      int          port;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   vec_t vecs[8];

   logic [35:0]      sbq[N_REQ][$];
   int               wait_cnt[N_REQ];
   logic [N_REQ-1:0] accepted;
   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] exp_g;
   logic [31:0]      held;
   logic [35:0]      exp_rsp;
   logic             draining;

   initial begin
      // Hand-computed expectations: {N,Z,C,V}.
      vecs[0] = '{0, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000};
      vecs[1] = '{1, ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
      vecs[2] = '{0, ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110};
      vecs[3] = '{1, ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000};
      vecs[4] = '{0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
      vecs[5] = '{1, ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
      vecs[6] = '{0, ALU_OR,  32'h0000_00A5, 32'h0000_005A, 32'h0000_00FF, 4'b0000};
      vecs[7] = '{1, ALU_AND, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 4'b1000};

      // ---------------- reset state, no grant under reset ----------------
      rst         = 1'b1;
      req_valid   = '1;
      rsp_ready   = '1;
      req_a[0]    = 32'd1;  req_b[0] = 32'd2;  req_control[0] = ALU_ADD;
      req_a[1]    = 32'd10; req_b[1] = 32'd3;  req_control[1] = ALU_SUB;
      repeat (2) @(negedge clk);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_result", rsp_result, 0);
      check("reset_rsp_flags", rsp_flags, 0);
      check("reset_no_grant", req_ready, 0);

      // ---------------- round robin, both ports busy ----------------
      #1 rst = 1'b0;
      #1 check("rr_first_grant", req_ready, 2'b01);
      for (int k = 1; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("rr_grant_%0d", k), req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
         check($sformatf("rr_rsp_valid_%0d", k), rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
      end
      @(posedge clk); #1 req_valid = '0;
      repeat (2) @(posedge clk);

      // ---------------- directed vector table ----------------
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         req_valid                     = '0;
         req_valid[vecs[i].port]       = 1'b1;
         req_a[vecs[i].port]           = vecs[i].a;
         req_b[vecs[i].port]           = vecs[i].b;
         req_control[vecs[i].port]     = vecs[i].op;
         rsp_ready                     = '1;
         exp_g                         = '0;
         exp_g[vecs[i].port]           = 1'b1;
         @(negedge clk);
         check($sformatf("vec%0d_grant", i), req_ready, exp_g);
         @(posedge clk); #1 req_valid = '0;
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), rsp_valid[vecs[i].port], 1'b1);
         check($sformatf("vec%0d_result", i), rsp_result[vecs[i].port], vecs[i].res);
         check($sformatf("vec%0d_flags", i), rsp_flags[vecs[i].port], vecs[i].flg);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;

      // ---------------- port 1 stalled, port 0 streams ----------------
      req_valid      = '1;
      rsp_ready      = 2'b01;
      req_a[0]       = 32'd7;       req_b[0] = 32'd9;       req_control[0] = ALU_ADD;
      req_a[1]       = 32'h1234;    req_b[1] = 32'h4321;    req_control[1] = ALU_OR;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("stall_grant_%0d", k), req_ready, 2'b01);
         check($sformatf("stall_p1_valid_%0d", k), rsp_valid[1], 1'b1);
         check($sformatf("stall_p1_hold_%0d", k), rsp_result[1], 32'h0000_5335);
         check($sformatf("stall_p0_result_%0d", k), rsp_result[0], 32'd16);
      end
      @(posedge clk); #1 req_valid = '0; rsp_ready = '1;
      repeat (2) @(posedge clk);

      // ---------------- drain and refill in the same cycle ----------------
      #1;
      req_valid = 2'b01; req_a[0] = 32'd1; req_b[0] = 32'd1; req_control[0] = ALU_ADD;
      rsp_ready = 2'b00;
      @(posedge clk); #1;
      req_a[0] = 32'hA5; req_b[0] = 32'h5A; req_control[0] = ALU_OR;
      rsp_ready = 2'b01;
      @(negedge clk);
      check("refill_old_result", rsp_result[0], 32'd2);
      check("refill_grant", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      check("refill_valid_kept", rsp_valid[0], 1'b1);
      check("refill_new_result", rsp_result[0], 32'h0000_00FF);
      check("refill_new_flags", rsp_flags[0], 4'b0000);
      @(negedge clk);
      check("refill_drained", rsp_valid[0], 1'b0);

      // ---------------- asynchronous reset mid-operation ----------------
      @(posedge clk); #1;
      req_valid = '1; rsp_ready = '0;
      req_a[0] = 32'd3; req_b[0] = 32'd4; req_control[0] = ALU_ADD;
      req_a[1] = 32'd9; req_b[1] = 32'd2; req_control[1] = ALU_SUB;
      repeat (2) @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      check("pre_rst_valid", rsp_valid, 2'b11);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", rsp_valid, 0);
      check("async_rst_result", rsp_result, 0);
      check("async_rst_flags", rsp_flags, 0);
      req_valid = '1; rsp_ready = '1;
      #1 check("async_rst_no_grant", req_ready, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      #1 check("post_rst_first_grant", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = '0;
      repeat (3) @(posedge clk);

      // ---------------- randomized traffic with scoreboard ----------------
      accepted = '0;
      draining = 1'b0;
      for (int p = 0; p < N_REQ; p++) wait_cnt[p] = 0;
      for (int cyc = 0; cyc < N_RAND + 12; cyc++) begin
         @(posedge clk); #1;
         draining = (cyc >= N_RAND);
         for (int p = 0; p < N_REQ; p++) begin
            if (!req_valid[p] || accepted[p]) begin
               if (!draining && $urandom_range(0, 3) != 0) begin
                  req_valid[p]   = 1'b1;
                  req_control[p] = 2'($urandom_range(0, 3));
                  req_a[p]       = rand_operand();
                  req_b[p]       = rand_operand();
               end else begin
                  req_valid[p] = 1'b0;
               end
            end
            rsp_ready[p] = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
         end
         @(negedge clk);
         check("rand_onehot0", $onehot0(req_ready), 1'b1);
         elig = req_valid & (~rsp_valid | rsp_ready);
         check("rand_grant_eligible", req_ready & ~elig, 0);
         check("rand_work_conserving", |req_ready, |elig);
         for (int p = 0; p < N_REQ; p++) begin
            if (elig[p] && !req_ready[p]) wait_cnt[p]++;
            else wait_cnt[p] = 0;
            check("rand_fair_gap", wait_cnt[p] < N_REQ, 1'b1);
            if (rsp_valid[p]) begin
               check("rand_sb_depth", sbq[p].size(), 1);
               if (sbq[p].size() > 0) begin
                  exp_rsp = sbq[p][0];
                  check("rand_result", rsp_result[p], exp_rsp[31:0]);
                  check("rand_flags", rsp_flags[p], exp_rsp[35:32]);
                  if (rsp_ready[p]) void'(sbq[p].pop_front());
               end
            end else begin
               check("rand_no_loss", sbq[p].size(), 0);
            end
         end
         for (int p = 0; p < N_REQ; p++) begin
            if (req_ready[p]) sbq[p].push_back(ref_alu(req_control[p], req_a[p], req_b[p]));
         end
         accepted = req_ready;
      end
      for (int p = 0; p < N_REQ; p++) begin
         check("rand_final_empty", sbq[p].size(), 0);
         check("rand_final_idle", rsp_valid[p], 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run can never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter sharing one `alu` instance between `N_REQ` independent requesters. Each requester issues operations over a valid/ready request channel and receives result and flags over its own valid/ready response channel. At most one operation is accepted per cycle. Results are registered per requester, so a stalled consumer blocks only its own port.

## Interface
- `WIDTH`, default 32: operand width; must equal the `alu` datapath width.
- `N_REQ`, default 2: number of requesters, ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  [N_REQ]: request present.
- `req_ready`  out  [N_REQ]: request accepted this cycle (grant).
- `req_a`, `req_b`  in  [N_REQ][WIDTH]: operands.
- `req_control`  in  [N_REQ][2]: ALU op code (`ALU_ADD/SUB/AND/OR` encoding).
- `rsp_valid`  out  [N_REQ]: response held.
- `rsp_ready`  in  [N_REQ]: consumer takes response.
- `rsp_result`  out  [N_REQ][WIDTH]: registered ALU result.
- `rsp_flags`  out  [N_REQ][4]: registered {N,Z,C,V}.

## Operation
- Port i is eligible when `req_valid[i]` is high and its response slot is free: `!rsp_valid[i] || rsp_ready[i]`.
- Exactly one eligible port is granted per cycle; `req_ready` is one-hot or zero.
- Grant order is round-robin:
  - Search starts at `last_grant+1` and wraps modulo `N_REQ`.
  - `last_grant` updates only on an accepted transfer.
  - Idle cycles leave `last_grant` unchanged.
- Granted operands and control are muxed into the single `alu`. Its `result` and `flags` are captured into the granted port's response registers at the next edge, and `rsp_valid` is set.
- `rsp_valid[i]` clears on `rsp_valid && rsp_ready` unless port i is refilled in the same cycle. A simultaneous drain and refill keeps `rsp_valid` high with the new data.
- Response data is held stable while `rsp_valid && !rsp_ready`.
- Result and flags pass through unmodified. The arbiter does not reinterpret flags per opcode.
- Fairness: any port holding `req_valid` with a draining consumer is granted within `N_REQ` cycles.

## Timing
- Reset values:
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_flags` = 0.
  - `last_grant` = `N_REQ-1`, so port 0 wins the first contention.
- `req_ready` is combinational from `req_valid`, `rsp_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Once asserted, `req_valid` and payload must hold until accepted.
- Latency is 1 cycle: handshake at edge k gives `rsp_valid` at k+1.
- Aggregate throughput is 1 op/cycle. A single port with `rsp_ready` tied high sustains 1 op/cycle when uncontended.
- Reset asserted mid-operation: all responses are discarded immediately (asynchronous). No grant is issued while `rst` is high.
- The ALU path is combinational from request mux to response register, which sets the single-cycle critical path.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum for the 2-bit op codes.
  - Flag index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - `ALU_WIDTH=32`.
- One sub-module, `rr_arbiter`:
  - Parameter `N`.
  - Inputs `eligible[N]` and `advance`.
  - Outputs one-hot `grant[N]` and the registered `last_grant` pointer, with async reset.
- Top level: `rr_arbiter`, operand mux, one `alu` instance, and per-port response registers.

## Test plan
- Single port 0, `ALU_AND` of 0x0000F0F0 and 0x0000FF00, `rsp_ready`=1. Expect `rsp_valid[0]` one cycle later with result 0x0000F000. Flags match a standalone `alu` fed the same inputs.
- Both ports valid continuously, both `rsp_ready`=1. Expect grants 0,1,0,1… starting with port 0 after reset, and `rsp_valid` alternating each cycle.
- Port 1 `rsp_ready`=0 with a full slot, port 0 valid. Expect port 1 never granted, port 0 granted every cycle, and port 1 response held stable.
- Port 0 `rsp_valid`=1 and `rsp_ready`=1 with a new port 0 request in the same cycle. Expect `rsp_valid[0]` to stay high and `rsp_result` to update to the new op (`ALU_OR` 0xA5 | 0x5A = 0xFF).
- `rst` pulsed between edges while both responses are valid. Expect all `rsp_valid`, `rsp_result` and `rsp_flags` to go to 0 immediately. After release, port 0 wins the first contention.
- Random ADD/SUB/AND/OR traffic on 2 ports with random `rsp_ready` for 10k cycles. Scoreboard checks every response against a standalone `alu` model, ordered per port, with no loss or duplication and grant gap ≤ `N_REQ` cycles.
